adc_frame_packer: RTL and testbench

- Sits directly downstream of the DDR ADC capture stage, in the `data_clk` domain.
- Consumes the 17-bit sample word: bit 16 is the overrange (OR) flag, and bits 15:0 are the two's-complement sample.
- On `arm`, waits for a trigger condition, then records exactly `FRAME_LEN` consecutive samples.
- Packs the samples two per 32-bit word into an external FIFO write port, and reports overflow, abort and overrange statistics.

---
 rtl/adc_frame_packer.sv | 187 ++++++++++++++++++
 tb/tb_adc_frame_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// Triggered ADC frame capture: packs FRAME_LEN 16-bit samples two per 32-bit FIFO word.
// Define ADC_FRAME_HDR_EN to prepend a {16'hA5A5, sample_ts} header word to each frame.
module adc_frame_packer #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             data_clk,
  input  logic             reset,
  input  logic             adc_rdy,
  input  logic [16:0]      adc_data,
  input  logic             arm,
  input  logic [1:0]       trig_mode,
  input  logic [15:0]      trig_level,
  output logic [31:0]      fifo_data,
  output logic             fifo_wr,
  input  logic             fifo_full,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             aborted,
  output logic [CNT_W-1:0] or_count,
  output logic [1:0]       state
);

  // Index counter is widened so a narrow CNT_W can still address a whole frame.
  localparam int unsigned IdxW = (CNT_W > $clog2(FRAME_LEN)) ? CNT_W : $clog2(FRAME_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StArmed   = 2'b01,
    StCapture = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        prev_q, prev_d, pack_q, pack_d;
  logic               prev_valid_q, prev_valid_d;
  logic [IdxW-1:0]    idx_q, idx_d, smp_idx;
  logic [31:0]        data_q, data_d;
  logic               wr_q, wr_d, done_q, done_d, ovf_q, ovf_d, abort_q, abort_d;
  logic [CNT_W-1:0]   orc_q, orc_d;
  logic               trig_hit, take_smp;
  logic signed [15:0] cur_s, prev_s, level_s;
`ifdef ADC_FRAME_HDR_EN
  logic [CNT_W-1:0]   ts_q, ts_d;
`endif

  assign cur_s   = signed'(adc_data[15:0]);
  assign prev_s  = signed'(prev_q);
  assign level_s = signed'(trig_level);

  always_comb begin
    case (trig_mode)
      2'b01:   trig_hit = prev_valid_q && (prev_s < level_s) && (cur_s >= level_s);
      2'b10:   trig_hit = prev_valid_q && (prev_s > level_s) && (cur_s <= level_s);
      default: trig_hit = 1'b1;
    endcase
  end

  // The trigger sample is frame sample 0, so capture starts while still ARMED.
  assign take_smp = adc_rdy && ((state_q == StArmed && trig_hit) || state_q == StCapture);
  assign smp_idx  = (state_q == StCapture) ? idx_q : '0;

  always_ff @(posedge data_clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (arm && adc_rdy) state_d = StArmed;
      StArmed:   if (!adc_rdy) state_d = StIdle;
                 else if (trig_hit) state_d = StCapture;
      StCapture: if (!adc_rdy || idx_q == LastIdx) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    pack_d       = pack_q;
    idx_d        = idx_q;
    data_d       = data_q;
    wr_d         = 1'b0;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    abort_d      = abort_q;
    orc_d        = orc_q;
    case (state_q)
      StIdle: begin
        if (arm && adc_rdy) begin
          ovf_d        = 1'b0;
          abort_d      = 1'b0;
          orc_d        = '0;
          prev_valid_d = 1'b0;
        end
      end
      StArmed, StCapture: begin
        if (!adc_rdy) abort_d = 1'b1;
      end
      default: ;
    endcase
    if (state_q == StArmed && adc_rdy) begin
      prev_d       = adc_data[15:0];
      prev_valid_d = 1'b1;
    end
    if (take_smp) begin
      idx_d = smp_idx + IdxW'(1);
      if (!smp_idx[0]) begin
        pack_d = adc_data[15:0];
      end else if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_d   = 1'b1;
        data_d = {adc_data[15:0], pack_q};
      end
      if (adc_data[16] && orc_q != '1) orc_d = orc_q + CNT_W'(1);
      if (smp_idx == LastIdx) begin
        done_d = 1'b1;
        idx_d  = '0;
      end
    end
`ifdef ADC_FRAME_HDR_EN
    // Header fills the write slot of even sample 0, so data word timing is untouched.
    ts_d = adc_rdy ? ts_q + CNT_W'(1) : ts_q;
    if (state_q == StArmed && adc_rdy && trig_hit) begin
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_d   = 1'b1;
        data_d = {16'hA5A5, 16'(ts_q)};
      end
    end
`endif
  end

  always_ff @(posedge data_clk) begin
    if (reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      pack_q       <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      abort_q      <= 1'b0;
      orc_q        <= '0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      pack_q       <= pack_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      abort_q      <= abort_d;
      orc_q        <= orc_d;
    end
  end

`ifdef ADC_FRAME_HDR_EN
  always_ff @(posedge data_clk) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end
`endif

  assign fifo_data = data_q;
  assign fifo_wr   = wr_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign aborted   = abort_q;
  assign or_count  = orc_q;
  assign state     = state_q;
  assign busy      = (state_q == StArmed) || (state_q == StCapture);

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: directed and random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_adc_frame_packer;

  localparam int FL     = 8;
  localparam int MaxCyc = 48;

  logic        data_clk = 1'b0;
  logic        reset, adc_rdy, arm, fifo_full;
  logic [16:0] adc_data;
  logic [1:0]  trig_mode;
  logic [15:0] trig_level;
  logic [31:0] fifo_data, fifo_data2;
  logic        fifo_wr, fifo_wr2, busy, busy2, done, done2;
  logic        overflow, overflow2, aborted, aborted2;
  logic [15:0] or_count;
  logic [1:0]  or_count2;
  logic [1:0]  state, state2;

  always #5 data_clk = ~data_clk;

  adc_frame_packer #(.FRAME_LEN(FL), .CNT_W(16)) dut (
    .data_clk(data_clk), .reset(reset), .adc_rdy(adc_rdy), .adc_data(adc_data), .arm(arm),
    .trig_mode(trig_mode), .trig_level(trig_level), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
    .fifo_full(fifo_full), .busy(busy), .done(done), .overflow(overflow), .aborted(aborted),
    .or_count(or_count), .state(state)
  );

  // Narrow counter instance shares all stimulus and exposes OR-count saturation.
  adc_frame_packer #(.FRAME_LEN(FL), .CNT_W(2)) dut2 (
    .data_clk(data_clk), .reset(reset), .adc_rdy(adc_rdy), .adc_data(adc_data), .arm(arm),
    .trig_mode(trig_mode), .trig_level(trig_level), .fifo_data(fifo_data2), .fifo_wr(fifo_wr2),
    .fifo_full(fifo_full), .busy(busy2), .done(done2), .overflow(overflow2), .aborted(aborted2),
    .or_count(or_count2), .state(state2)
  );

  int n_chk = 0;
  int n_err = 0;

  logic        s_rdy  [MaxCyc];
  logic        s_full [MaxCyc];
  logic        s_arm  [MaxCyc];
  logic [16:0] s_dat  [MaxCyc];
  int          ncyc;

  int          exp_edge[$], got_edge[$], got_done[$];
  logic [31:0] exp_word[$], got_word[$];
  int          m_done, m_orc;
  logic        m_ovf, m_ab;
  logic [31:0] last_word, last_word2;
`ifdef ADC_FRAME_HDR_EN
  int unsigned ts_model = 0;
  int unsigned ts0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge data_clk);
`ifdef ADC_FRAME_HDR_EN
    if (reset) ts_model = 0;
    else if (adc_rdy) ts_model++;
`endif
    #1;
  endtask

  function automatic int sv(input logic [16:0] d);
    return int'($signed(d[15:0]));
  endfunction

  function automatic bit hit(input int c);
    int lv = int'($signed(trig_level));
    case (trig_mode)
      2'b01:   return (c > 1) && (sv(s_dat[c-1]) < lv) && (sv(s_dat[c]) >= lv);
      2'b10:   return (c > 1) && (sv(s_dat[c-1]) > lv) && (sv(s_dat[c]) <= lv);
      default: return 1'b1;
    endcase
  endfunction

  // Frame-level reference: locate the trigger, then derive words from the sample stream.
  task automatic model();
    int t = -1;
    exp_edge.delete();
    exp_word.delete();
    m_done = -1; m_orc = 0; m_ovf = 1'b0; m_ab = 1'b0;
    for (int c = 1; c < ncyc; c++) begin
      if (!s_rdy[c]) begin m_ab = 1'b1; break; end
      if (hit(c)) begin t = c; break; end
    end
    if (t >= 0) begin
`ifdef ADC_FRAME_HDR_EN
      if (s_full[t]) m_ovf = 1'b1;
      else begin
        exp_edge.push_back(t);
        exp_word.push_back({16'hA5A5, 16'(ts0 + t)});
        last_word  = {16'hA5A5, 16'(ts0 + t)};
        last_word2 = {16'hA5A5, 14'd0, 2'((ts0 + t) & 3)};
      end
`endif
      for (int i = 0; i < FL; i++) begin
        int c = t + i;
        if (c >= ncyc || !s_rdy[c]) begin m_ab = 1'b1; break; end
        if (s_dat[c][16]) m_orc++;
        if (i % 2 == 1) begin
          if (s_full[c]) m_ovf = 1'b1;
          else begin
            exp_edge.push_back(c);
            exp_word.push_back({s_dat[c][15:0], s_dat[c-1][15:0]});
            last_word  = {s_dat[c][15:0], s_dat[c-1][15:0]};
            last_word2 = last_word;
          end
        end
        if (i == FL - 1) m_done = c;
      end
    end
  endtask

  task automatic clr_scn(input int n, input logic [1:0] mode, input logic [15:0] lvl);
    ncyc = n; trig_mode = mode; trig_level = lvl;
    for (int c = 0; c < MaxCyc; c++) begin
      s_rdy[c] = 1'b1; s_full[c] = 1'b0; s_arm[c] = 1'b0;
      s_dat[c] = {1'b0, 16'(c - 1)};
    end
    s_arm[0] = 1'b1;
    s_rdy[n-1] = 1'b0;
  endtask

  task automatic run_scn(input string name);
    int nw;
`ifdef ADC_FRAME_HDR_EN
    ts0 = ts_model;
`endif
    model();
    got_edge.delete(); got_word.delete(); got_done.delete();
    for (int c = 0; c < ncyc; c++) begin
      adc_rdy = s_rdy[c]; adc_data = s_dat[c]; fifo_full = s_full[c]; arm = s_arm[c];
      tick();
      if (fifo_wr) begin got_edge.push_back(c); got_word.push_back(fifo_data); end
      if (done) got_done.push_back(c);
      if (c == 0) begin
        chk({name, ".armed_state"}, 32'(state), 32'd1);
        chk({name, ".armed_busy"}, 32'(busy), 32'd1);
        chk({name, ".armed_ovf"}, 32'(overflow), 32'd0);
        chk({name, ".armed_abort"}, 32'(aborted), 32'd0);
        chk({name, ".armed_orc"}, 32'(or_count), 32'd0);
      end
    end
    arm = 1'b0; fifo_full = 1'b0; adc_rdy = 1'b1;
    chk({name, ".n_wr"}, 32'(got_word.size()), 32'(exp_word.size()));
    nw = (got_word.size() < exp_word.size()) ? got_word.size() : exp_word.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s.wr%0d_edge", name, i), 32'(got_edge[i]), 32'(exp_edge[i]));
      chk($sformatf("%s.wr%0d_data", name, i), got_word[i], exp_word[i]);
    end
    chk({name, ".n_done"}, 32'(got_done.size()), (m_done >= 0) ? 32'd1 : 32'd0);
    if (got_done.size() == 1 && m_done >= 0)
      chk({name, ".done_edge"}, 32'(got_done[0]), 32'(m_done));
    chk({name, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({name, ".abort"}, 32'(aborted), 32'(m_ab));
    chk({name, ".orc"}, 32'(or_count), 32'(m_orc > 65535 ? 65535 : m_orc));
    chk({name, ".orc_sat2"}, 32'(or_count2), 32'(m_orc > 3 ? 3 : m_orc));
    chk({name, ".end_state"}, 32'(state), 32'd0);
    chk({name, ".end_busy"}, 32'(busy), 32'd0);
    chk({name, ".end_wr"}, 32'(fifo_wr), 32'd0);
    chk({name, ".end_done"}, 32'(done), 32'd0);
    chk({name, ".hold_data"}, fifo_data, last_word);
    chk({name, ".n2_state"}, 32'(state2), 32'd0);
    chk({name, ".n2_busy"}, 32'(busy2), 32'd0);
    chk({name, ".n2_wr_done"}, 32'({fifo_wr2, done2}), 32'd0);
    chk({name, ".n2_ovf_abort"}, 32'({overflow2, aborted2}), 32'({m_ovf, m_ab}));
    chk({name, ".n2_data"}, fifo_data2, last_word2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; adc_rdy = 1'b0; arm = 1'b0; fifo_full = 1'b0; adc_data = '0;
    trig_mode = 2'b00; trig_level = '0;
    last_word = '0; last_word2 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.flags", 32'({busy, done, fifo_wr, overflow, aborted}), 32'd0);
    chk("rst.data", fifo_data, 32'd0);
    chk("rst.orc", 32'(or_count), 32'd0);
    chk("rst.orc2", 32'(or_count2), 32'd0);

    // Reset in the middle of a frame after setting sticky flags.
    adc_rdy = 1'b1; arm = 1'b1; tick(); arm = 1'b0;
    adc_data = 17'h10005; tick();
    adc_data = 17'h00006; fifo_full = 1'b1; tick(); fifo_full = 1'b0;
    chk("mid.state", 32'(state), 32'd2);
    chk("mid.orc", 32'(or_count), 32'd1);
    chk("mid.ovf", 32'(overflow), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    last_word = '0; last_word2 = '0;
    chk("mid_rst.state", 32'(state), 32'd0);
    chk("mid_rst.flags", 32'({busy, done, fifo_wr, overflow, aborted}), 32'd0);
    chk("mid_rst.orc", 32'(or_count), 32'd0);

    // 15 idle valid samples so the first trigger lands at sample_ts 0x0010.
    adc_rdy = 1'b1;
    for (int i = 0; i < 15; i++) tick();

    clr_scn(12, 2'b00, 16'd0);
    s_arm[3] = 1'b1;
    run_scn("imm");

    clr_scn(16, 2'b01, 16'd100);
    s_dat[1] = 17'd120; s_dat[2] = 17'd90; s_dat[3] = 17'd95; s_dat[4] = 17'd99;
    for (int c = 5; c < 16; c++) s_dat[c] = 17'(100 + 5 * (c - 5));
    run_scn("rise");

    clr_scn(12, 2'b00, 16'd0);
    s_full[4] = 1'b1;
    run_scn("bp");

    clr_scn(8, 2'b00, 16'd0);
    s_rdy[4] = 1'b0;
    run_scn("abort");

    arm = 1'b1; adc_rdy = 1'b0; tick(); arm = 1'b0; adc_rdy = 1'b1;
    chk("arm_nordy.state", 32'(state), 32'd0);
    chk("arm_nordy.abort", 32'(aborted), 32'd1);

    clr_scn(12, 2'b00, 16'd0);
    s_dat[1][16] = 1'b1; s_dat[3][16] = 1'b1; s_dat[6][16] = 1'b1;
    run_scn("or3");

    clr_scn(12, 2'b00, 16'd0);
    s_dat[1][16] = 1'b1; s_dat[2][16] = 1'b1; s_dat[4][16] = 1'b1;
    s_dat[5][16] = 1'b1; s_dat[7][16] = 1'b1;
    run_scn("or5");

    for (int r = 0; r < 24; r++) begin
      int lvl = int'($urandom_range(0, 2000)) - 1000;
      clr_scn(40, 2'($urandom_range(0, 3)), 16'(lvl));
      for (int c = 1; c < 39; c++) begin
        s_dat[c]  = {($urandom_range(0, 3) == 0), 16'(lvl + int'($urandom_range(0, 30)) - 15)};
        s_full[c] = ($urandom_range(0, 5) == 0);
        s_rdy[c]  = ($urandom_range(0, 39) != 0);
      end
      run_scn($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
